// File: rtl/vscale_tohost_monitor_pkg.sv
// Shared constants for the HTIF tohost monitor.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the monitor FSM encoding, the default HTIF PCR data width and the
// tohost CSR address, which matches the vscale CSR address map.
package vscale_tohost_monitor_pkg;

  // Default width of the HTIF PCR request/response data path.
  localparam int HTIF_PCR_WIDTH = 64;

  // Address of the tohost CSR in the vscale CSR address map.
  localparam logic [11:0] CSR_ADDR_TO_HOST = 12'h780;

  // Monitor FSM encoding. The clear states exist in the encoding in every
  // build. They are only reachable when the tohost clear feature is compiled in.
  localparam logic [2:0] ST_WAIT     = 3'd0;
  localparam logic [2:0] ST_RD_REQ   = 3'd1;
  localparam logic [2:0] ST_RD_RESP  = 3'd2;
  localparam logic [2:0] ST_CLR_REQ  = 3'd3;
  localparam logic [2:0] ST_CLR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/vscale_tohost_monitor_sat.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible the cycle after the enabling edge.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset, clears the count
//   clr_i  - synchronous clear (lower priority than reset)
//   en_i   - count enable
//   cnt_o  - current count
module vscale_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vscale_tohost_monitor.sv
// HTIF tohost monitor: polls tohost over the PCR port and decodes pass/fail/timeout.
// Latency: poll period POLL_GAP+3 cycles minimum; done one cycle after the final response.
// Backpressure: request fields held until req_ready; resp_ready held until resp_valid.
//
// Optional feature macro: VSCALE_TOHOST_CLEAR_EN. When it is defined, tohost is
// written back to 0 after a nonzero read, before DONE.
//
// Ports:
//   clk, reset            - sole clock, synchronous active-high reset
//   max_cycles            - timeout budget in cycles, 0 disables the timeout
//   htif_pcr_req_*        - request channel to the core (valid/ready, rw, addr, data)
//   htif_pcr_resp_*       - response channel from the core (valid/ready, data)
//   done, pass, timeout   - sticky status; pass is meaningful once done is set
//   fail_code             - tohost >> 1 for a failing test, otherwise 0
//   cycle_count           - cycles since reset release, saturating
module vscale_tohost_monitor
  import vscale_tohost_monitor_pkg::*;
#(
  parameter int PCR_WIDTH = HTIF_PCR_WIDTH,
  parameter int POLL_GAP  = 4,
  parameter int CNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     max_cycles,
  output logic                 htif_pcr_req_valid,
  input  logic                 htif_pcr_req_ready,
  output logic                 htif_pcr_req_rw,
  output logic [11:0]          htif_pcr_req_addr,
  output logic [PCR_WIDTH-1:0] htif_pcr_req_data,
  input  logic                 htif_pcr_resp_valid,
  output logic                 htif_pcr_resp_ready,
  input  logic [PCR_WIDTH-1:0] htif_pcr_resp_data,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [PCR_WIDTH-1:0] fail_code,
  output logic [CNT_W-1:0]     cycle_count
);

  // The gap counter only has to reach POLL_GAP. Keep it at least 1 bit wide.
  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP);

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic                 pass_q;
  logic                 pass_d;
  logic                 timeout_q;
  logic                 timeout_d;
  logic [PCR_WIDTH-1:0] fail_q;
  logic [PCR_WIDTH-1:0] fail_d;

  logic [CNT_W-1:0]     cyc_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 gap_last;
  logic                 gap_clr;
  logic                 tmo_hit;
  logic                 resp_zero;
  logic                 resp_one;

  // Free-running cycle counter. It is cleared only by reset.
  vscale_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .en_i  (1'b1),
    .cnt_o (cyc_cnt)
  );

  // The gap counter runs only in WAIT. It restarts at 0 on every entry to WAIT,
  // so WAIT lasts POLL_GAP+1 cycles.
  assign gap_last = (gap_cnt == GAP_LAST);
  assign gap_clr  = (state_q != ST_WAIT) || gap_last;

  vscale_sat_counter #(
    .W (GAP_W)
  ) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (gap_clr),
    .en_i  (state_q == ST_WAIT),
    .cnt_o (gap_cnt)
  );

  // Timeout uses the registered count, so no input reaches an output
  // combinationally.
  assign tmo_hit   = (max_cycles != '0) && (cyc_cnt >= max_cycles);
  assign resp_zero = (htif_pcr_resp_data == '0);
  assign resp_one  = (htif_pcr_resp_data == PCR_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    fail_d    = fail_q;
    case (state_q)
      ST_WAIT: begin
        if (tmo_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if (gap_last) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        // A request the core accepts on this edge is already in flight. Collect
        // its response before honouring the timeout, so the core is never left
        // holding an unanswered response.
        if (htif_pcr_req_ready) begin
          state_d = ST_RD_RESP;
        end else if (tmo_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (htif_pcr_resp_valid) begin
          if (resp_zero) begin
            if (tmo_hit) begin
              state_d   = ST_DONE;
              timeout_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            // A tohost result beats a timeout that fires on the same edge.
            if (resp_one) begin
              pass_d = 1'b1;
            end else begin
              fail_d = htif_pcr_resp_data >> 1;
            end
`ifdef VSCALE_TOHOST_CLEAR_EN
            state_d = ST_CLR_REQ;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef VSCALE_TOHOST_CLEAR_EN
      ST_CLR_REQ: begin
        if (htif_pcr_req_ready) begin
          state_d = ST_CLR_RESP;
        end
      end
      ST_CLR_RESP: begin
        // The write response carries nothing useful. Only the handshake matters.
        if (htif_pcr_resp_valid) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WAIT;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      fail_q    <= fail_d;
    end
  end

  // All handshake and status outputs decode from registered state only.
`ifdef VSCALE_TOHOST_CLEAR_EN
  assign htif_pcr_req_valid  = (state_q == ST_RD_REQ)  || (state_q == ST_CLR_REQ);
  assign htif_pcr_resp_ready = (state_q == ST_RD_RESP) || (state_q == ST_CLR_RESP);
  assign htif_pcr_req_rw     = (state_q == ST_CLR_REQ);
`else
  assign htif_pcr_req_valid  = (state_q == ST_RD_REQ);
  assign htif_pcr_resp_ready = (state_q == ST_RD_RESP);
  assign htif_pcr_req_rw     = 1'b0;
`endif

  assign htif_pcr_req_addr = CSR_ADDR_TO_HOST;
  assign htif_pcr_req_data = '0;

  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_q;
  assign cycle_count = cyc_cnt;

endmodule

// File: tb/tb_vscale_tohost_monitor.sv
// Bench for vscale_tohost_monitor: a reactive HTIF responder plus a result scoreboard.
// Latency: n/a.
// Backpressure: responder throttles req_ready and resp_valid by programmable delays.
module tb_vscale_tohost_monitor;

  localparam int PW  = 64;
  localparam int GAP = 4;
  localparam int CW  = 64;

`ifdef VSCALE_TOHOST_CLEAR_EN
  localparam int   EXP_WR         = 1;
  localparam logic EXP_DONE_AT_NZ = 1'b0;
`else
  localparam int   EXP_WR         = 0;
  localparam logic EXP_DONE_AT_NZ = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] max_cycles = '0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic          req_rw;
  logic [11:0]   req_addr;
  logic [PW-1:0] req_data;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  logic [PW-1:0] resp_data = '0;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [PW-1:0] fail_code;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  vscale_tohost_monitor #(
    .PCR_WIDTH (PW),
    .POLL_GAP  (GAP),
    .CNT_W     (CW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .max_cycles          (max_cycles),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .fail_code           (fail_code),
    .cycle_count         (cycle_count)
  );

  typedef struct {
    logic          pass;
    logic          tmo;
    logic [PW-1:0] code;
  } exp_t;

  exp_t          sb[$];
  logic [PW-1:0] rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Responder configuration and observations.
  int            req_delay = 0;
  int            resp_delay = 0;
  int            n_reads = 0;
  int            n_writes = 0;
  int            wr_data_bad = 0;
  int            stab_bad = 0;
  int            rdy_bad = 0;
  int            rdy_wait = 0;
  int            resp_wait = 0;
  int            last_rd_cyc = 0;
  int            prev_rd_cyc = 0;
  bit            pending = 0;
  bit            pend_rw = 0;
  bit            last_req_v = 0;
  bit            last_resp_rdy = 0;
  bit            seen_v = 0;
  logic          cap_rw = 1'b0;
  logic [11:0]   cap_addr = '0;
  logic [PW-1:0] cap_data = '0;
  logic [CW-1:0] prev_cnt = '0;
  logic [CW-1:0] last_resp_cnt = '0;
  logic          done_at_nz = 1'bx;

  always @(posedge clk) cyc <= cyc + 1;

  // Reactive HTIF responder. It runs 1 ns after each falling edge and first works
  // out which handshakes completed on the rising edge just passed. Then it drives
  // the inputs for the next rising edge.
  initial begin : responder
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        pending       = 0;
        seen_v        = 0;
        last_req_v    = 0;
        last_resp_rdy = 0;
        rdy_wait      = req_delay;
      end else begin
        if (last_req_v && req_ready) begin
          req_ready = 1'b0;
          pending   = 1;
          pend_rw   = cap_rw;
          resp_wait = resp_delay;
          seen_v    = 0;
          rdy_wait  = req_delay;
          if (cap_rw) begin
            n_writes++;
            if (cap_data !== '0) wr_data_bad++;
          end else begin
            n_reads++;
            prev_rd_cyc = last_rd_cyc;
            last_rd_cyc = cyc;
          end
        end
        if (last_resp_rdy && resp_valid) begin
          resp_valid = 1'b0;
          pending    = 0;
          if (!pend_rw) begin
            last_resp_cnt = prev_cnt;
            if (resp_data != '0) done_at_nz = done;
          end
        end
        if (pending && !resp_ready) rdy_bad++;
        if (req_valid) begin
          if (pending) begin
            stab_bad++;
          end else if (!seen_v) begin
            seen_v   = 1;
            cap_rw   = req_rw;
            cap_addr = req_addr;
            cap_data = req_data;
            if (req_addr !== 12'h780) stab_bad++;
          end else if (req_rw !== cap_rw || req_addr !== cap_addr || req_data !== cap_data) begin
            stab_bad++;
          end
        end else if (seen_v) begin
          stab_bad++;
          seen_v = 0;
        end
        if (pending && !resp_valid) begin
          if (resp_wait <= 0) begin
            resp_valid = 1'b1;
            if (pend_rw) resp_data = {$urandom, $urandom};
            else if (rsp_q.size() > 0) resp_data = rsp_q.pop_front();
            else resp_data = '0;
          end else begin
            resp_wait--;
          end
        end
        if (req_valid && !pending && !req_ready) begin
          if (rdy_wait <= 0) req_ready = 1'b1;
          else rdy_wait--;
        end
        last_req_v    = req_valid;
        last_resp_rdy = resp_ready;
      end
      prev_cnt = cycle_count;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic do_reset(input int rd, input int sd, input logic [CW-1:0] mc);
    @(negedge clk);
    #2;
    reset       = 1'b1;
    req_delay   = rd;
    resp_delay  = sd;
    max_cycles  = mc;
    rsp_q.delete();
    n_reads     = 0;
    n_writes    = 0;
    wr_data_bad = 0;
    stab_bad    = 0;
    rdy_bad     = 0;
    done_at_nz  = 1'bx;
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #2;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    do_reset(0, 0, '0);
    total++;
    if ({req_valid, resp_ready, req_rw, done, pass, timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {req_valid, resp_ready, req_rw, done, pass, timeout});
    end
    total++;
    if (fail_code !== '0 || cycle_count !== '0) begin
      bad++;
      $display("FAIL reset_counts: fail_code=%h cycle_count=%0d want 0/0", fail_code, cycle_count);
    end
    total++;
    if (req_addr !== 12'h780 || req_data !== '0) begin
      bad++;
      $display("FAIL reset_addr: addr=%h data=%h want 780/0", req_addr, req_data);
    end
  endtask

  task automatic test_pass();
    exp_t e;
    do_reset(0, 0, '0);
    rsp_q = '{64'd0, 64'd0, 64'd0, 64'd1};
    sb.push_back('{pass: 1'b1, tmo: 1'b0, code: '0});
    release_reset();
    wait_done(300);
    e = sb.pop_front();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL pass_done: got %b want 1", done); end
    total++;
    if (pass !== e.pass || timeout !== e.tmo || fail_code !== e.code) begin
      bad++;
      $display("FAIL pass_result: pass=%b tmo=%b code=%h want %b/%b/%h", pass, timeout, fail_code, e.pass, e.tmo, e.code);
    end
    total++;
    if (n_reads !== 4 || n_writes !== EXP_WR || wr_data_bad !== 0) begin
      bad++;
      $display("FAIL pass_txns: reads=%0d writes=%0d wbad=%0d want 4/%0d/0", n_reads, n_writes, wr_data_bad, EXP_WR);
    end
    total++;
    if (done_at_nz !== EXP_DONE_AT_NZ) begin
      bad++;
      $display("FAIL pass_latency: done after result=%b want %b", done_at_nz, EXP_DONE_AT_NZ);
    end
    total++;
    if (last_rd_cyc - prev_rd_cyc !== GAP + 3) begin
      bad++;
      $display("FAIL poll_period: got %0d want %0d", last_rd_cyc - prev_rd_cyc, GAP + 3);
    end
  endtask

  task automatic test_fail_code();
    exp_t e;
    do_reset(0, 0, '0);
    rsp_q = '{64'h2B};
    sb.push_back('{pass: 1'b0, tmo: 1'b0, code: 64'h15});
    release_reset();
    wait_done(300);
    e = sb.pop_front();
    total++;
    if (done !== 1'b1 || pass !== e.pass || timeout !== e.tmo || fail_code !== e.code) begin
      bad++;
      $display("FAIL fail_code: done=%b pass=%b tmo=%b code=%h want 1/%b/%b/%h", done, pass, timeout, fail_code, e.pass, e.tmo, e.code);
    end
    total++;
    if (n_writes !== EXP_WR || wr_data_bad !== 0) begin
      bad++;
      $display("FAIL fail_clear: writes=%0d wbad=%0d want %0d/0", n_writes, wr_data_bad, EXP_WR);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset(7, 5, '0);
    rsp_q = '{64'd0, 64'd1};
    sb.push_back('{pass: 1'b1, tmo: 1'b0, code: '0});
    release_reset();
    wait_done(500);
    e = sb.pop_front();
    total++;
    if (done !== 1'b1 || pass !== e.pass || timeout !== e.tmo) begin
      bad++;
      $display("FAIL bp_result: done=%b pass=%b tmo=%b want 1/%b/%b", done, pass, timeout, e.pass, e.tmo);
    end
    total++;
    if (stab_bad !== 0) begin bad++; $display("FAIL bp_req_stable: violations=%0d want 0", stab_bad); end
    total++;
    if (rdy_bad !== 0) begin bad++; $display("FAIL bp_resp_ready: drops=%0d want 0", rdy_bad); end
    total++;
    if (n_reads !== 2 || n_writes !== EXP_WR) begin
      bad++;
      $display("FAIL bp_no_dup: reads=%0d writes=%0d want 2/%0d", n_reads, n_writes, EXP_WR);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   reads_at_done;
    logic [CW-1:0] cnt_at_done;
    do_reset(0, 0, 64'd50);
    sb.push_back('{pass: 1'b0, tmo: 1'b1, code: '0});
    release_reset();
    wait_done(200);
    cnt_at_done = cycle_count;
    e = sb.pop_front();
    total++;
    if (done !== 1'b1 || pass !== e.pass || timeout !== e.tmo || fail_code !== e.code) begin
      bad++;
      $display("FAIL timeout_result: done=%b pass=%b tmo=%b code=%h want 1/%b/%b/%h", done, pass, timeout, fail_code, e.pass, e.tmo, e.code);
    end
    total++;
    if (cnt_at_done < 50 || cnt_at_done > 52) begin
      bad++;
      $display("FAIL timeout_cycle: cycle_count=%0d want 50..52", cnt_at_done);
    end
    reads_at_done = n_reads;
    repeat (20) @(negedge clk);
    #2;
    total++;
    if (done !== 1'b1 || req_valid !== 1'b0 || n_reads !== reads_at_done) begin
      bad++;
      $display("FAIL done_absorb: done=%b req_valid=%b reads=%0d want 1/0/%0d", done, req_valid, n_reads, reads_at_done);
    end
  endtask

  task automatic test_no_timeout();
    do_reset(0, 0, '0);
    release_reset();
    repeat (10000) @(negedge clk);
    #2;
    total++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: done=%b tmo=%b want 0/0", done, timeout);
    end
    total++;
    if (n_reads < (10000 / (GAP + 3)) - 2) begin
      bad++;
      $display("FAIL no_timeout_polls: reads=%0d want >= %0d", n_reads, (10000 / (GAP + 3)) - 2);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    // Responses land when cycle_count is 6, 13, 20, so the third one (data 1)
    // is accepted on the very edge where the count reaches the budget of 20.
    do_reset(0, 0, 64'd20);
    rsp_q = '{64'd0, 64'd0, 64'd1};
    sb.push_back('{pass: 1'b1, tmo: 1'b0, code: '0});
    release_reset();
    wait_done(200);
    e = sb.pop_front();
    total++;
    if (last_resp_cnt !== 64'd20) begin
      bad++;
      $display("FAIL simul_align: result accepted at cycle_count=%0d want 20", last_resp_cnt);
    end
    total++;
    if (done !== 1'b1 || pass !== e.pass || timeout !== e.tmo) begin
      bad++;
      $display("FAIL simul_result: done=%b pass=%b tmo=%b want 1/%b/%b", done, pass, timeout, e.pass, e.tmo);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   k;
    do_reset(0, 10, '0);
    release_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (resp_ready) break;
    end
    total++;
    if (resp_ready !== 1'b1) begin bad++; $display("FAIL mid_reach_resp: resp_ready=%b want 1", resp_ready); end
    reset = 1'b1;
    @(negedge clk);
    #2;
    total++;
    if ({req_valid, resp_ready, req_rw, done, pass, timeout} !== 6'b0 || fail_code !== '0 || cycle_count !== '0) begin
      bad++;
      $display("FAIL mid_reset_outs: ctrl=%b code=%h cnt=%0d want 0/0/0", {req_valid, resp_ready, req_rw, done, pass, timeout}, fail_code, cycle_count);
    end
    rsp_q.delete();
    rsp_q.push_back(64'd1);
    resp_delay = 0;
    sb.push_back('{pass: 1'b1, tmo: 1'b0, code: '0});
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      #2;
      if (req_valid) begin
        k = i;
        break;
      end
    end
    total++;
    if (k !== GAP + 1) begin bad++; $display("FAIL mid_resume_gap: first request after %0d cycles want %0d", k, GAP + 1); end
    wait_done(200);
    e = sb.pop_front();
    total++;
    if (done !== 1'b1 || pass !== e.pass || timeout !== e.tmo) begin
      bad++;
      $display("FAIL mid_resume_result: done=%b pass=%b tmo=%b want 1/%b/%b", done, pass, timeout, e.pass, e.tmo);
    end
  endtask

  initial begin : main
    test_reset();
    test_pass();
    test_fail_code();
    test_backpressure();
    test_timeout();
    test_no_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vscale_tohost_monitor.md
# vscale_tohost_monitor

Synthesizable host-side HTIF controller that drives the core's HTIF PCR request/response port. It polls the `tohost` CSR and decodes a nonzero value as pass (`1`) or fail (`value >> 1`). It optionally clears `tohost` after each nonzero read and enforces a cycle budget. It sits directly upstream of `vscale_top`'s `htif_pcr_*` port and replaces per-cycle behavioural polling with a handshake-correct, FPGA-usable stage.

## Interface
- `PCR_WIDTH`, default `HTIF_PCR_WIDTH` (64): PCR data width.
- `POLL_GAP`, default 4: idle cycles between completed polls; 0 means back-to-back.
- `CNT_W`, default 64: width of the cycle counter and timeout compare.
- `clk` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `max_cycles` input CNT_W: timeout budget; 0 disables the timeout.
- `htif_pcr_req_valid` output 1: request valid.
- `htif_pcr_req_ready` input 1: core accepts the request.
- `htif_pcr_req_rw` output 1: 0 = read, 1 = write.
- `htif_pcr_req_addr` output 12: always `CSR_ADDR_TO_HOST`.
- `htif_pcr_req_data` output PCR_WIDTH: write data, always 0.
- `htif_pcr_resp_valid` input 1: response valid.
- `htif_pcr_resp_ready` output 1: monitor accepts the response.
- `htif_pcr_resp_data` input PCR_WIDTH: read data.
- `done` output 1: sticky; the test has ended.
- `pass` output 1: sticky; valid when `done`.
- `timeout` output 1: sticky; the budget was exceeded.
- `fail_code` output PCR_WIDTH: `tohost >> 1` on fail, otherwise 0.
- `cycle_count` output CNT_W: cycles since reset deassertion, saturating.

## Operation
- States: WAIT, RD_REQ, RD_RESP, CLR_REQ, CLR_RESP, DONE.
- WAIT:
  - The gap counter counts up to `POLL_GAP`, then the FSM moves to RD_REQ.
  - With `POLL_GAP=0`, WAIT lasts exactly 1 cycle.
- RD_REQ:
  - `req_valid=1`, `rw=0`.
  - Fields are held stable until `req_ready`; then go to RD_RESP.
- RD_RESP:
  - `resp_ready=1`; on `resp_valid` the monitor samples the data.
  - Data 0 goes to WAIT.
  - Data 1 sets `pass`.
  - Any other nonzero value sets `fail_code = data >> 1`.
  - Nonzero data goes to CLR_REQ if clear is compiled in, else to DONE.
- CLR_REQ/CLR_RESP:
  - Write 0 to `tohost` (`rw=1`) using the same handshake, then go to DONE.
  - The write response data is ignored.
- DONE:
  - Absorbing until reset.
  - `done=1`; `req_valid=0`; `resp_ready=0`.
- `resp_ready` is 1 only in RD_RESP or CLR_RESP; `req_valid` is 1 only in RD_REQ or CLR_REQ.
- `cycle_count` increments every cycle after reset and saturates at all-ones.
- Timeout condition: `max_cycles != 0` and `cycle_count >= max_cycles`.
  - From WAIT/RD_REQ: go straight to DONE with `timeout=1`, `pass=0`, `done=1`.
  - From RD_RESP/CLR_REQ/CLR_RESP: finish the current handshake first, then go to DONE.
- Simultaneous events:
  - If a nonzero response is accepted in the same cycle the timeout fires, the `tohost` result wins and `timeout` stays 0.
  - A zero response with timeout goes to DONE with `timeout=1`.

## Timing
- Reset values: all outputs 0; state WAIT; counters 0.
- `req_addr` is constant `CSR_ADDR_TO_HOST` in every state; `req_data` is constant 0.
- Minimum poll period is `POLL_GAP+3` cycles when ready/valid are immediate: WAIT≥1, RD_REQ 1, RD_RESP 1.
- Pass/fail latency: `done` asserts in the cycle after the nonzero response is accepted (no clear), or after the clear response is accepted (clear on).
- All status outputs are registered; there are no combinational paths from inputs to outputs.
- A `reset` asserted mid-transaction returns the FSM to WAIT on the next edge. The core is reset on the same signal, so there is no outstanding-response tracking.

## Configuration
- `VSCALE_TOHOST_CLEAR_EN` defined: CLR_REQ/CLR_RESP are present, and `tohost` is written to 0 after each nonzero read.
- Not defined: the clear states are removed, `htif_pcr_req_rw` is tied to 0, and the monitor goes directly from RD_RESP to DONE.

## Structure
- Shared package/header (`vscale_ctrl_constants.vh` style) holds:
  - the state encoding localparams (WAIT..DONE);
  - `HTIF_PCR_WIDTH`;
  - `CSR_ADDR_TO_HOST`, taken from `vscale_csr_addr_map.vh`.
- One sub-module, `vscale_sat_counter` (width-parameterized saturating up-counter with clear), is instantiated for both `cycle_count` and the poll-gap counter.

## Test plan
- Pass: the responder returns 0 ×3, then 1 → `done=1`, `pass=1`, `fail_code=0`. With clear, exactly one `rw=1` write of 0 follows the read.
- Fail code: the responder returns `0x2B` → `done=1`, `pass=0`, `fail_code=0x15`.
- Backpressure: `req_ready` is held low for 7 cycles → `req_valid`, `rw` and `addr` stay stable and no duplicate request is issued. `resp_valid` delayed 5 cycles → `resp_ready` stays high throughout.
- Timeout: `max_cycles=50`, always-zero responses → `timeout=1` and `done=1` at `cycle_count` 50 (±1 in-flight handshake), `pass=0`. With `max_cycles=0`, no timeout after 10000 cycles.
- Simultaneous: response data 1 accepted in the same cycle `cycle_count` reaches `max_cycles` → `pass=1`, `timeout=0`.
- Reset mid-op: `reset` asserted during RD_RESP → the next cycle has all outputs 0 and state WAIT; polling resumes after `POLL_GAP`.
